// File: rtl/pwm_duty_sequencer_if.sv
// Button inputs and duty/level outputs shared by the sequencer, the PWM divider and the seven-segment controller.
// The sequencer uses the master modport; the button and display side uses the slave modport.
interface pwm_duty_sequencer_if;
  logic       btn_up;
  logic       btn_down;
  logic       btn_auto;
  logic [7:0] duty;
  logic [3:0] level;
  logic       load;
  logic       auto_active;

  // No valid/ready handshake: duty and level are sampled continuously and load is an advisory one-cycle strobe.
  modport master (
    input  btn_up, btn_down, btn_auto,
    output duty, level, load, auto_active
  );

  modport slave (
    output btn_up, btn_down, btn_auto,
    input  duty, level, load, auto_active
  );
endinterface

// File: rtl/pwm_duty_sequencer.sv
// Converts button edges into a bounded level and a saturated 8-bit PWM duty with a change strobe.
// Define AUTO_RAMP_EN to build the auto-ramp states, the btn_auto toggle and the tick prescaler.
module pwm_duty_sequencer #(
  parameter int STEP      = 25,
  parameter int MAX_LEVEL = 10,
  parameter int TICK_DIV  = 5000000
) (
  input  logic                 clk,
  input  logic                 rst,
  pwm_duty_sequencer_if.master io,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    ST_MANUAL    = 2'd0,
    ST_AUTO_UP   = 2'd1,
    ST_AUTO_DOWN = 2'd2
  } state_e;

  localparam logic [3:0]  LVL_MAX = 4'(MAX_LEVEL);
  localparam logic [11:0] STEP_W  = 12'(STEP);

  state_e      state_q, state_d;
  logic [3:0]  level_q, level_d;
  logic [7:0]  duty_q, duty_d;
  logic        load_q, load_d;
  logic        auto_active_q, auto_active_d;
  logic        up_hist_q, dn_hist_q;
  logic        up_e_q, up_e_d;
  logic        dn_e_q, dn_e_d;
  logic        lvl_inc, lvl_dec;
  logic        auto_e;
  logic        tick;
  logic [11:0] prod;

  // Edges are registered, which gives the one-clock latency from first sampling a button high.
  always_comb begin
    up_e_d = io.btn_up & ~up_hist_q;
    dn_e_d = io.btn_down & ~dn_hist_q;
  end

`ifdef AUTO_RAMP_EN
  localparam int PW = $clog2(TICK_DIV);

  logic          auto_hist_q;
  logic          auto_e_q, auto_e_d;
  logic [PW-1:0] presc_q, presc_d;

  assign auto_e = auto_e_q;
  assign tick   = (state_q != ST_MANUAL) && (presc_q == PW'(TICK_DIV - 1));

  always_comb begin
    auto_e_d = io.btn_auto & ~auto_hist_q;
    presc_d  = '0;
    // The prescaler only runs while staying inside the auto states; entry and exit restart it from 0.
    if ((state_q != ST_MANUAL) && (state_d != ST_MANUAL)) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      auto_hist_q <= 1'b1;
      auto_e_q    <= 1'b0;
      presc_q     <= '0;
    end else begin
      auto_hist_q <= io.btn_auto;
      auto_e_q    <= auto_e_d;
      presc_q     <= presc_d;
    end
  end
`else
  logic unused_btn_auto;

  assign unused_btn_auto = io.btn_auto;
  assign auto_e          = 1'b0;
  assign tick            = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_MANUAL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; priority is btn_auto edge, then up/down edge, then tick.
  always_comb begin
    state_d = state_q;
    lvl_inc = 1'b0;
    lvl_dec = 1'b0;
    case (state_q)
      ST_MANUAL: begin
        if (auto_e) begin
          state_d = ST_AUTO_UP;
        end else if (up_e_q && !dn_e_q) begin
          lvl_inc = (level_q < LVL_MAX);
        end else if (dn_e_q && !up_e_q) begin
          lvl_dec = (level_q != 4'd0);
        end
      end
      ST_AUTO_UP: begin
        if (auto_e || up_e_q || dn_e_q) begin
          state_d = ST_MANUAL;
        end else if (tick) begin
          if (level_q < LVL_MAX) begin
            lvl_inc = 1'b1;
          end else begin
            state_d = ST_AUTO_DOWN;
            lvl_dec = 1'b1;
          end
        end
      end
      ST_AUTO_DOWN: begin
        if (auto_e || up_e_q || dn_e_q) begin
          state_d = ST_MANUAL;
        end else if (tick) begin
          if (level_q != 4'd0) begin
            lvl_dec = 1'b1;
          end else begin
            state_d = ST_AUTO_UP;
            lvl_inc = 1'b1;
          end
        end
      end
      default: state_d = ST_MANUAL;
    endcase
  end

  // Output logic.
  always_comb begin
    auto_active_d = (state_d != ST_MANUAL);
    dbg_state     = state_q;
  end

  always_comb begin
    level_d = level_q;
    if (lvl_inc) begin
      level_d = level_q + 4'd1;
    end else if (lvl_dec) begin
      level_d = level_q - 4'd1;
    end
    prod   = 12'(level_d) * STEP_W;
    duty_d = (prod > 12'd255) ? 8'hFF : prod[7:0];
    // Saturated and limit no-ops leave duty unchanged, so they raise no strobe.
    load_d = (duty_d != duty_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_q       <= 4'd0;
      duty_q        <= 8'd0;
      load_q        <= 1'b0;
      auto_active_q <= 1'b0;
      up_hist_q     <= 1'b1;
      dn_hist_q     <= 1'b1;
      up_e_q        <= 1'b0;
      dn_e_q        <= 1'b0;
    end else begin
      level_q       <= level_d;
      duty_q        <= duty_d;
      load_q        <= load_d;
      auto_active_q <= auto_active_d;
      up_hist_q     <= io.btn_up;
      dn_hist_q     <= io.btn_down;
      up_e_q        <= up_e_d;
      dn_e_q        <= dn_e_d;
    end
  end

  assign io.duty        = duty_q;
  assign io.level       = level_q;
  assign io.load        = load_q;
  assign io.auto_active = auto_active_q;

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Directed bench for pwm_duty_sequencer: two instances (STEP=25 and STEP=30, both TICK_DIV=4).
// The auto-ramp section depends on whether AUTO_RAMP_EN is defined.
module tb_pwm_duty_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_a, dbg_b;
  int         checks = 0;
  int         errors = 0;
  int         exp_lvl, prev_lvl;
  bit         dir_up;

  pwm_duty_sequencer_if io_a ();
  pwm_duty_sequencer_if io_b ();

  always #5 clk = ~clk;

  pwm_duty_sequencer #(.STEP(25), .MAX_LEVEL(10), .TICK_DIV(4)) u_dut_a (
    .clk       (clk),
    .rst       (rst),
    .io        (io_a.master),
    .dbg_state (dbg_a)
  );

  pwm_duty_sequencer #(.STEP(30), .MAX_LEVEL(10), .TICK_DIV(4)) u_dut_b (
    .clk       (clk),
    .rst       (rst),
    .io        (io_b.master),
    .dbg_state (dbg_b)
  );

  function automatic int duty_of(input int lvl, input int step);
    return (lvl * step > 255) ? 255 : lvl * step;
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One-cycle pulse on DUT A; level must not move before the second edge.
  task automatic pulse_a(input logic up, input logic dn, input int prev);
    io_a.btn_up   = up;
    io_a.btn_down = dn;
    tick();
    io_a.btn_up   = 1'b0;
    io_a.btn_down = 1'b0;
    check("a_latency_level", 16'(io_a.level), 16'(prev));
    tick();
  endtask

  task automatic pulse_b_up(input int prev);
    io_b.btn_up = 1'b1;
    tick();
    io_b.btn_up = 1'b0;
    check("b_latency_level", 16'(io_b.level), 16'(prev));
    tick();
  endtask

  task automatic pulse_auto_a;
    io_a.btn_auto = 1'b1;
    tick();
    io_a.btn_auto = 1'b0;
    tick();
  endtask

  initial begin
    rst           = 1'b0;
    io_a.btn_up   = 1'b1;
    io_a.btn_down = 1'b0;
    io_a.btn_auto = 1'b0;
    io_b.btn_up   = 1'b0;
    io_b.btn_down = 1'b0;
    io_b.btn_auto = 1'b0;
    tick(3);
    check("rst_level", 16'(io_a.level), 16'd0);
    check("rst_duty", 16'(io_a.duty), 16'd0);
    check("rst_load", 16'(io_a.load), 16'd0);
    check("rst_auto_active", 16'(io_a.auto_active), 16'd0);

    // btn_up held high through reset release must not count as an edge.
    rst = 1'b1;
    tick(4);
    check("held_level", 16'(io_a.level), 16'd0);
    check("held_load", 16'(io_a.load), 16'd0);
    io_a.btn_up = 1'b0;
    tick(3);
    check("held_release_level", 16'(io_a.level), 16'd0);

    // 12 up pulses: saturates at 10, no strobe on pulses 11 and 12.
    exp_lvl = 0;
    for (int i = 1; i <= 12; i++) begin
      prev_lvl = exp_lvl;
      if (exp_lvl < 10) exp_lvl++;
      pulse_a(1'b1, 1'b0, prev_lvl);
      check("up_level", 16'(io_a.level), 16'(exp_lvl));
      check("up_duty", 16'(io_a.duty), 16'(duty_of(exp_lvl, 25)));
      check("up_load", 16'(io_a.load), 16'(exp_lvl != prev_lvl));
      tick();
      check("up_load_clear", 16'(io_a.load), 16'd0);
    end

    // 11 down pulses: reaches 0, no strobe on the 11th.
    for (int i = 1; i <= 11; i++) begin
      prev_lvl = exp_lvl;
      if (exp_lvl > 0) exp_lvl--;
      pulse_a(1'b0, 1'b1, prev_lvl);
      check("down_level", 16'(io_a.level), 16'(exp_lvl));
      check("down_duty", 16'(io_a.duty), 16'(duty_of(exp_lvl, 25)));
      check("down_load", 16'(io_a.load), 16'(exp_lvl != prev_lvl));
      tick();
      check("down_load_clear", 16'(io_a.load), 16'd0);
    end

    // Up to 5, then up and down together: no change, no strobe.
    for (int i = 0; i < 5; i++) begin
      pulse_a(1'b1, 1'b0, i);
      tick();
    end
    check("five_level", 16'(io_a.level), 16'd5);
    check("five_duty", 16'(io_a.duty), 16'd125);
    pulse_a(1'b1, 1'b1, 5);
    check("both_level", 16'(io_a.level), 16'd5);
    check("both_load", 16'(io_a.load), 16'd0);
    tick();
    check("both_level_after", 16'(io_a.level), 16'd5);

    // STEP=30: level 9 saturates duty at 255; level 10 keeps 255 with no strobe.
    for (int i = 1; i <= 10; i++) begin
      pulse_b_up(i - 1);
      check("sat_level", 16'(io_b.level), 16'(i));
      check("sat_duty", 16'(io_b.duty), 16'(duty_of(i, 30)));
      check("sat_load", 16'(io_b.load), 16'(i <= 9));
      tick();
    end
    check("sat_final_duty", 16'(io_b.duty), 16'd255);

`ifdef AUTO_RAMP_EN
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("auto_pre_level", 16'(io_a.level), 16'd0);
    pulse_auto_a();
    check("auto_entry_active", 16'(io_a.auto_active), 16'd1);
    check("auto_entry_level", 16'(io_a.level), 16'd0);

    // 0 -> 1..10 -> 9..0 -> 1, then on up to 6; one step every 4 cycles.
    exp_lvl = 0;
    dir_up  = 1'b1;
    for (int s = 0; s < 26; s++) begin
      tick(3);
      check("ramp_hold_level", 16'(io_a.level), 16'(exp_lvl));
      if (dir_up) begin
        if (exp_lvl < 10) exp_lvl++;
        else begin dir_up = 1'b0; exp_lvl--; end
      end else begin
        if (exp_lvl > 0) exp_lvl--;
        else begin dir_up = 1'b1; exp_lvl++; end
      end
      tick();
      check("ramp_level", 16'(io_a.level), 16'(exp_lvl));
      check("ramp_duty", 16'(io_a.duty), 16'(duty_of(exp_lvl, 25)));
      check("ramp_load", 16'(io_a.load), 16'd1);
      check("ramp_active", 16'(io_a.auto_active), 16'd1);
    end
    check("ramp_at_six", 16'(io_a.level), 16'd6);

    // Down pulse mid-ramp: back to MANUAL with level held.
    io_a.btn_down = 1'b1;
    tick();
    io_a.btn_down = 1'b0;
    tick();
    check("abort_active", 16'(io_a.auto_active), 16'd0);
    check("abort_level", 16'(io_a.level), 16'd6);
    check("abort_load", 16'(io_a.load), 16'd0);
    tick(12);
    check("abort_hold_level", 16'(io_a.level), 16'd6);

    // Ramp 6 -> 7,8,9,10,9,8,7 then assert reset between edges.
    pulse_auto_a();
    check("reentry_active", 16'(io_a.auto_active), 16'd1);
    tick(28);
    check("desc_level", 16'(io_a.level), 16'd7);
    check("desc_load", 16'(io_a.load), 16'd1);
    #1;
    rst = 1'b0;
    #1;
    check("async_level", 16'(io_a.level), 16'd0);
    check("async_duty", 16'(io_a.duty), 16'd0);
    check("async_load", 16'(io_a.load), 16'd0);
    check("async_active", 16'(io_a.auto_active), 16'd0);
    tick();
    rst = 1'b1;
    tick(12);
    check("post_rst_level", 16'(io_a.level), 16'd0);
    check("post_rst_active", 16'(io_a.auto_active), 16'd0);
`else
    for (int i = 0; i < 3; i++) begin
      pulse_auto_a();
      tick(2);
    end
    tick(10);
    check("noauto_active", 16'(io_a.auto_active), 16'd0);
    check("noauto_level", 16'(io_a.level), 16'd5);
    check("noauto_load", 16'(io_a.load), 16'd0);
    check("noauto_duty", 16'(io_a.duty), 16'd125);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
